// File: rtl/mdu_unit.sv
// mdu_unit: E-stage multiply/divide unit with HI/LO registers.
// A multi-cycle operation computes its full result when it starts, holds it
// in hi_tmp/lo_tmp, and commits it to HI/LO only when the busy countdown ends.
// The start/busy pair lets the hazard unit stall md-class instructions.
`timescale 1ns/1ps

module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi_tmp;
    logic [31:0]      lo_tmp;
    logic             dz_tmp;

    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [63:0] div_s_res;
    logic        [63:0] div_u_res;
    logic        [31:0] res_hi;
    logic        [31:0] res_lo;
    logic               is_md_op;
    logic               is_div;

    // Signed divide returning {remainder, quotient}; the one overflowing case
    // (most negative / -1) is pinned to the architectural answer explicitly.
    function automatic logic [63:0] div_signed(input logic [31:0] n, input logic [31:0] d);
        logic signed [31:0] sn;
        logic signed [31:0] sd;
        logic signed [31:0] q;
        logic signed [31:0] r;
        if (d == 32'd0) begin
            return 64'd0;
        end
        if ((n == 32'h8000_0000) && (d == 32'hFFFF_FFFF)) begin
            return {32'h0000_0000, 32'h8000_0000};
        end
        sn = $signed(n);
        sd = $signed(d);
        q  = sn / sd;
        r  = sn % sd;
        return {r, q};
    endfunction

    // Unsigned divide returning {remainder, quotient}.
    function automatic logic [63:0] div_unsigned(input logic [31:0] n, input logic [31:0] d);
        if (d == 32'd0) begin
            return 64'd0;
        end
        return {n % d, n / d};
    endfunction

    assign busy = (state == ST_RUN);

    // Operation decode, full-width arithmetic and result selection.
    always_comb begin
        is_md_op  = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
        is_div    = (md_op == OP_DIV) || (md_op == OP_DIVU);
        start     = is_md_op && !busy;
        a_sx      = $signed({{32{a[31]}}, a});
        b_sx      = $signed({{32{b[31]}}, b});
        prod_s    = a_sx * b_sx;
        prod_u    = {32'd0, a} * {32'd0, b};
        div_s_res = div_signed(a, b);
        div_u_res = div_unsigned(a, b);
        res_hi    = 32'd0;
        res_lo    = 32'd0;
        case (md_op)
            OP_MULT:  begin res_hi = prod_s[63:32];    res_lo = prod_s[31:0];    end
            OP_MULTU: begin res_hi = prod_u[63:32];    res_lo = prod_u[31:0];    end
            OP_DIV:   begin res_hi = div_s_res[63:32]; res_lo = div_s_res[31:0]; end
            OP_DIVU:  begin res_hi = div_u_res[63:32]; res_lo = div_u_res[31:0]; end
            default:  begin res_hi = 32'd0;            res_lo = 32'd0;           end
        endcase
        md_out = 32'd0;
        if (md_op == OP_MFHI) begin
            md_out = hi;
        end else if (md_op == OP_MFLO) begin
            md_out = lo;
        end
    end

    // Control FSM, countdown, result latch/commit and MTHI/MTLO writes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            hi_tmp <= 32'd0;
            lo_tmp <= 32'd0;
            dz_tmp <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (start) begin
                state  <= ST_RUN;
                cnt    <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                hi_tmp <= res_hi;
                lo_tmp <= res_lo;
                dz_tmp <= is_div && (b == 32'd0);
            end else if (md_op == OP_MTHI) begin
                hi <= a;
            end else if (md_op == OP_MTLO) begin
                lo <= a;
            end
        end else begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                state <= ST_IDLE;
                if (!dz_tmp) begin
                    hi <= hi_tmp;
                    lo <= lo_tmp;
                end
            end
        end
    end

endmodule
